// File: rtl/fnd_scan_driver.sv
// Binary count -> 4 BCD digits (serial double-dabble, 16 cycles sample to o_bcd), scanned onto a 4-digit
// common-anode display at SCAN_HZ per digit; no backpressure, input changes mid-conversion are picked up on return to IDLE.
module fnd_scan_driver #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int SCAN_HZ       = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] digit,
  input  logic [3:0]  i_dp,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont,
  output logic [15:0] o_bcd,
  output logic        o_busy
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [13:0] src_q, src_nxt;
  logic [13:0] bin_q, bin_nxt;
  logic [15:0] scr_q, scr_nxt, scr_adj;
  logic [15:0] bcd_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic [13:0] clamped;

  assign clamped = (digit > 14'd9999) ? 14'd9999 : digit;
  assign o_busy  = (state != IDLE);

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // src_q holds the raw input so an out-of-range value is not reconverted every pass
  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    bin_nxt   = bin_q;
    scr_nxt   = scr_q;
    cnt_nxt   = cnt_q;
    bcd_nxt   = o_bcd;
    case (state)
      IDLE: begin
        if (digit != src_q) begin
          src_nxt   = digit;
          bin_nxt   = clamped;
          scr_nxt   = 16'h0000;
          cnt_nxt   = 4'd14;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        scr_nxt = {scr_adj[14:0], bin_q[13]};
        bin_nxt = {bin_q[12:0], 1'b0};
        cnt_nxt = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_nxt = DONE;
      end
      DONE: begin
        bcd_nxt   = scr_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      src_q <= '0;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      o_bcd <= '0;
    end else begin
      state <= state_nxt;
      src_q <= src_nxt;
      bin_q <= bin_nxt;
      scr_q <= scr_nxt;
      cnt_q <= cnt_nxt;
      o_bcd <= bcd_nxt;
    end
  end

  logic [PW-1:0] ps_q;
  logic [1:0]    idx_q;
  logic          tick;

  assign tick = (ps_q == PS_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q  <= '0;
      idx_q <= '0;
    end else begin
      ps_q <= tick ? '0 : ps_q + 1'b1;
      if (tick) idx_q <= idx_q + 2'd1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [3:0] blank;
  logic [3:0] nib;
  logic [3:0] com_nxt;
  logic [7:0] font_nxt;

  // A digit blanks only when it and every digit above it are zero
  always_comb begin
    blank    = 4'b0000;
    blank[3] = BLANK_LEADING && (o_bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (o_bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (o_bcd[7:4] == 4'd0);
    nib      = o_bcd[{idx_q, 2'b00} +: 4];
    com_nxt  = ~(4'b0001 << idx_q);
    font_nxt = {~i_dp[idx_q], blank[idx_q] ? 7'h7F : seg7(nib)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fndCom  <= 4'b1110;
      fndFont <= 8'hC0;
    end else begin
      fndCom  <= com_nxt;
      fndFont <= font_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: scoreboard of expected BCD results popped on each completed conversion,
// plus scan-order, blanking and reset scenarios on a blanking and a non-blanking instance.
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] digit;
  logic [3:0]  i_dp;
  logic [3:0]  fndCom, nb_com;
  logic [7:0]  fndFont, nb_font;
  logic [15:0] o_bcd, nb_bcd;
  logic        o_busy, nb_busy;

  int checks = 0;
  int errors = 0;
  int last_digit = 0;
  logic [15:0] exp_q[$];
  logic prev_busy = 1'b0;

  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  fnd_scan_driver #(.CLK_HZ(100), .SCAN_HZ(25), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .digit(digit), .i_dp(i_dp),
    .fndCom(fndCom), .fndFont(fndFont), .o_bcd(o_bcd), .o_busy(o_busy)
  );

  fnd_scan_driver #(.CLK_HZ(100), .SCAN_HZ(25), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .digit(digit), .i_dp(i_dp),
    .fndCom(nb_com), .fndFont(nb_font), .o_bcd(nb_bcd), .o_busy(nb_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [7:0] exp_font(input int v, input logic [3:0] dp, input int d, input bit bl);
    logic [15:0] b;
    logic [7:0]  s;
    b = ref_bcd(v);
    s = seg_tab[int'(b[4*d +: 4])];
    if (bl && d > 0 && (b >> (4*d)) == 16'd0) s = 8'hFF;
    return {~dp[d], s[6:0]};
  endfunction

  function automatic int com_idx(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Scoreboard: every completed conversion (busy falling outside reset) pops one expectation
  always @(negedge clk) begin
    if (reset && prev_busy && !o_busy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got o_bcd %h with no conversion expected", o_bcd);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (o_bcd !== e) begin
          errors++;
          $display("FAIL sb_bcd: got %h expected %h", o_bcd, e);
        end
      end
    end
    prev_busy <= o_busy;
  end

  task automatic wait_drain();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_busy) break;
    end
    if (k == 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic apply(input int v);
    @(negedge clk);
    digit = 14'(v);
    if (v != last_digit) exp_q.push_back(ref_bcd(v));
    last_digit = v;
    wait_drain();
  endtask

  task automatic scan_all(input int v);
    logic [3:0] seen;
    int d, dn;
    seen = 4'b0000;
    for (int s = 0; s < 17; s++) begin
      @(negedge clk);
      d  = com_idx(fndCom);
      dn = com_idx(nb_com);
      checks++;
      if (d < 0 || dn < 0) begin
        errors++;
        $display("FAIL scan_com: got %b/%b expected a single active digit", fndCom, nb_com);
      end else begin
        seen[d] = 1'b1;
        checks++;
        if (fndFont !== exp_font(v, i_dp, d, 1'b1)) begin
          errors++;
          $display("FAIL font_blank v=%0d d=%0d: got %h expected %h", v, d, fndFont, exp_font(v, i_dp, d, 1'b1));
        end
        checks++;
        if (nb_font !== exp_font(v, i_dp, dn, 1'b0)) begin
          errors++;
          $display("FAIL font_noblank v=%0d d=%0d: got %h expected %h", v, dn, nb_font, exp_font(v, i_dp, dn, 1'b0));
        end
      end
    end
    checks++;
    if (seen !== 4'hF) begin
      errors++;
      $display("FAIL scan_coverage v=%0d: got %b expected 1111", v, seen);
    end
  endtask

  task automatic test_reset();
    int busy_cnt;
    reset = 1'b0;
    digit = 14'd1234;
    i_dp  = 4'b0000;
    repeat (3) @(negedge clk);
    checks += 4;
    if (fndCom !== 4'b1110) begin errors++; $display("FAIL rst_com: got %b expected 1110", fndCom); end
    if (fndFont !== 8'hC0) begin errors++; $display("FAIL rst_font: got %h expected c0", fndFont); end
    if (o_bcd !== 16'h0000) begin errors++; $display("FAIL rst_bcd: got %h expected 0000", o_bcd); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
    exp_q.push_back(ref_bcd(1234));
    last_digit = 1234;
    reset = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (o_busy) busy_cnt++;
      if (k == 15) begin
        checks++;
        if (o_bcd !== 16'h0000) begin errors++; $display("FAIL latency_early: got %h expected 0000", o_bcd); end
      end
    end
    checks += 2;
    if (o_bcd !== 16'h1234) begin errors++; $display("FAIL latency_bcd: got %h expected 1234", o_bcd); end
    if (busy_cnt != 15) begin errors++; $display("FAIL busy_len: got %0d expected 15", busy_cnt); end
    wait_drain();
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    bit found;
    @(negedge clk);
    i_dp = 4'b0100;
    prev = fndCom;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (fndCom == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = fndCom;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_sync: got %b expected transition to 1110", fndCom);
    end else begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 4; c++) begin
          if (d != 0 || c != 0) @(negedge clk);
          checks += 2;
          if (fndCom !== ~(4'b0001 << d)) begin
            errors++;
            $display("FAIL scan_order d=%0d c=%0d: got %b expected %b", d, c, fndCom, ~(4'b0001 << d));
          end
          if (fndFont !== exp_font(1234, 4'b0100, d, 1'b1)) begin
            errors++;
            $display("FAIL scan_font d=%0d: got %h expected %h", d, fndFont, exp_font(1234, 4'b0100, d, 1'b1));
          end
        end
      end
      @(negedge clk);
      checks++;
      if (fndCom !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b expected 1110", fndCom); end
    end
  endtask

  task automatic test_clamp_blank();
    i_dp = 4'b0000;
    apply(7);
    repeat (2) @(negedge clk);
    scan_all(7);
    i_dp = 4'b0010;
    scan_all(7);
    i_dp = 4'b0000;
    apply(1000);
    repeat (2) @(negedge clk);
    scan_all(1000);
    apply(0);
    repeat (2) @(negedge clk);
    scan_all(0);
    apply(12000);
    repeat (2) @(negedge clk);
    scan_all(12000);
  endtask

  task automatic test_change_during();
    int low_run;
    bit early_low, saw_first, done;
    @(negedge clk);
    digit = 14'd1;
    exp_q.push_back(ref_bcd(1));
    @(negedge clk);
    digit = 14'd42;
    @(negedge clk);
    digit = 14'd9876;
    exp_q.push_back(ref_bcd(9876));
    last_digit = 9876;
    low_run = 0;
    early_low = 1'b0;
    saw_first = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (o_bcd == 16'h0001) saw_first = 1'b1;
      if (o_bcd == 16'h9876 && !o_busy) done = 1'b1;
      else if (!o_busy) begin
        low_run++;
        if (low_run >= 2) early_low = 1'b1;
      end else low_run = 0;
    end
    checks += 3;
    if (!done) begin errors++; $display("FAIL chg_final: got %h expected 9876", o_bcd); end
    if (!saw_first) begin errors++; $display("FAIL chg_first: got %b expected first result 0001 seen", saw_first); end
    if (early_low) begin errors++; $display("FAIL chg_busy: got idle before 9876 expected busy until loaded"); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit found;
    @(negedge clk);
    digit = 14'd5555;
    exp_q.push_back(ref_bcd(5555));
    last_digit = 5555;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
    if (o_bcd !== 16'h0000) begin errors++; $display("FAIL midrst_bcd: got %h expected 0000", o_bcd); end
    if (fndCom !== 4'b1110) begin errors++; $display("FAIL midrst_com: got %b expected 1110", fndCom); end
    @(negedge clk);
    #1 reset = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(posedge clk);
      #1;
      if (o_bcd == 16'h5555) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_recover: got %h expected 5555", o_bcd); end
    wait_drain();
  endtask

  task automatic test_zero_reset();
    int busy_seen;
    apply(0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy) busy_seen++;
    end
    checks += 2;
    if (busy_seen != 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_seen); end
    if (o_bcd !== 16'h0000) begin errors++; $display("FAIL zero_bcd: got %h expected 0000", o_bcd); end
  endtask

  task automatic test_sweep();
    for (int v = 0; v <= 9999; v += 7) apply(v);
    apply(9999);
    apply(10000);
    apply(16383);
    apply(1);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_clamp_blank();
    test_change_during();
    test_reset_mid();
    test_zero_reset();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
